// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared register-file definitions. Clear-engine state
//                encoding and the default register width/count reused by
//                the decode and writeback stages.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   typedef enum logic [1:0] {
      RF_IDLE  = 2'd0,
      RF_CLEAR = 2'd1,
      RF_DONE  = 2'd2
   } rf_state_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file_bypass_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_bypass_if
//  Description : Bus between the decode/writeback logic (master) and the
//                register file (slave).
//  Signals     : ra       - packed read addresses, port k at ra[k*AW +: AW]
//                rd       - packed read data, port k at rd[k*XLEN +: XLEN]
//                we/wa/wd - writeback port
//                clr_req  - bulk clear request
//                clr_busy - clear in progress
//                clr_done - one-cycle clear completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_bypass_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) ();
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   ra;
   logic [NRD*XLEN-1:0] rd;
   logic                we;
   logic [AW-1:0]       wa;
   logic [XLEN-1:0]     wd;
   logic                clr_req;
   logic                clr_busy;
   logic                clr_done;

   modport master (
      output ra, we, wa, wd, clr_req,
      input  rd, clr_busy, clr_done
   );

   modport slave (
      input  ra, we, wa, wd, clr_req,
      output rd, clr_busy, clr_done
   );
endinterface : reg_file_bypass_if
`default_nettype wire

// File: rtl/rf_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rf_clear_fsm
//  Description : Bulk-clear engine. Walks a pointer over every register,
//                one per cycle, then pulses clr_done for a single cycle.
//  Ports       : clk, reset_n  - clock, synchronous active-low reset
//                clr_req       - clear request, sampled only in IDLE
//                clr_busy      - registered, high for exactly NREGS cycles
//                clr_done      - registered one-cycle completion pulse
//                clr_we        - array write strobe for the clear pointer
//                clr_addr      - register being cleared this cycle
//                wr_allow      - external writes permitted (IDLE or DONE)
//                byp_allow     - write-to-read bypass permitted (IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_clear_fsm
   import rf_pkg::*;
#(
   parameter int NREGS = RF_NREGS
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     clr_we,
   output logic [$clog2(NREGS)-1:0] clr_addr,
   output logic                     wr_allow,
   output logic                     byp_allow
);
   localparam int            AW     = $clog2(NREGS);
   localparam logic [AW-1:0] C_LAST = AW'(NREGS - 1);

   rf_state_t     r_state;
   logic [AW-1:0] r_ptr;
   logic          r_busy;
   logic          r_done;

   // busy/done are kept as their own flops so both outputs come straight
   // from registers and never from clr_req.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= RF_IDLE;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            RF_IDLE: begin
               r_done <= 1'b0;
               if (clr_req) begin
                  r_state <= RF_CLEAR;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RF_CLEAR: begin
               r_ptr <= r_ptr + 1'b1;
               // Exit on the last register; the pointer never wraps in use.
               if (r_ptr == C_LAST) begin
                  r_state <= RF_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            RF_DONE: begin
               r_state <= RF_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= RF_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy  = r_busy;
   assign clr_done  = r_done;
   assign clr_we    = r_busy;
   assign clr_addr  = r_ptr;
   assign wr_allow  = !r_busy;
   assign byp_allow = (r_state == RF_IDLE);
endmodule : rf_clear_fsm
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_bypass
//  Description : Parametrised register bank for the decode stage. NRD
//                combinational read ports with optional same-cycle
//                write-to-read bypass, optional hardwired zero register,
//                one writeback port and a multi-cycle bulk-clear engine.
//  Ports       : clk     - system clock
//                reset_n - synchronous active-low reset (zeroes the array)
//                bus     - reg_file_bypass_if slave: ra/rd read ports,
//                          we/wa/wd write port, clr_req/clr_busy/clr_done
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bypass
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NREGS    = RF_NREGS,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   reg_file_bypass_if.slave   bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] r_regs [NREGS];

   logic            w_clr_we;
   logic [AW-1:0]   w_clr_addr;
   logic            w_wr_allow;
   logic            w_byp_allow;
   logic            w_wa_is_zero;
   logic            w_wr_en;

   rf_clear_fsm #(
      .NREGS (NREGS)
   ) u_clear_fsm (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_req   (bus.clr_req),
      .clr_busy  (bus.clr_busy),
      .clr_done  (bus.clr_done),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr),
      .wr_allow  (w_wr_allow),
      .byp_allow (w_byp_allow)
   );

   // A write to the hardwired zero register is swallowed here so that
   // both the array update and the bypass see the same qualification.
   assign w_wa_is_zero = (ZERO_REG != 0) && (bus.wa == '0);
   assign w_wr_en      = bus.we && w_wr_allow && !w_wa_is_zero;

   // The clear engine owns the write port while busy; external writes
   // are dropped during that window rather than queued.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_clr_we) begin
         r_regs[w_clr_addr] <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.wa] <= bus.wd;
      end
   end

   generate
      for (genvar k = 0; k < NRD; k++) begin : g_rd_port
         logic [AW-1:0]   w_ra;
         logic [XLEN-1:0] w_rd;

         assign w_ra = bus.ra[k*AW +: AW];

         // Bypass is restricted to IDLE: during a clear the write is
         // dropped, so forwarding wd would show data that never lands.
         always_comb begin
            w_rd = r_regs[w_ra];
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
               w_rd = '0;
            end else if ((BYPASS != 0) && w_byp_allow && bus.we &&
                         !w_wa_is_zero && (bus.wa == w_ra)) begin
               w_rd = bus.wd;
            end
         end

         assign bus.rd[k*XLEN +: XLEN] = w_rd;
      end
   endgenerate
endmodule : reg_file_bypass
`default_nettype wire

// File: tb/tb_reg_file_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_bypass
//  Description : Self-checking bench. Two instances (bypass on / off) share
//                one stimulus stream; expected values are queued by the
//                stimulus and consumed by a negedge monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_bypass;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;

   localparam int K_A_RD0  = 0;
   localparam int K_A_RD1  = 1;
   localparam int K_A_BUSY = 2;
   localparam int K_A_DONE = 3;
   localparam int K_B_RD0  = 4;
   localparam int K_B_RD1  = 5;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } item_t;

   logic        clk;
   logic        reset_n;
   logic [4:0]  ra0, ra1;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        clr_req;

   int total = 0;
   int bad   = 0;
   item_t sb[$];

   reg_file_bypass_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) a_if ();
   reg_file_bypass_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b_if ();

   assign a_if.ra = {ra1, ra0};
   assign a_if.we = we;
   assign a_if.wa = wa;
   assign a_if.wd = wd;
   assign a_if.clr_req = clr_req;
   assign b_if.ra = {ra1, ra0};
   assign b_if.we = we;
   assign b_if.wa = wa;
   assign b_if.wd = wd;
   assign b_if.clr_req = clr_req;

   reg_file_bypass #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
      u_dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
   reg_file_bypass #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0))
      u_dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] observe(input int kind);
      case (kind)
         K_A_RD0:  return a_if.rd[31:0];
         K_A_RD1:  return a_if.rd[63:32];
         K_A_BUSY: return {31'd0, a_if.clr_busy};
         K_A_DONE: return {31'd0, a_if.clr_done};
         K_B_RD0:  return b_if.rd[31:0];
         K_B_RD1:  return b_if.rd[63:32];
         default:  return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Monitor: consumes every expectation queued for the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         item_t it;
         logic [31:0] act;
         it  = sb.pop_front();
         act = observe(it.kind);
         total++;
         if (act !== it.exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h at %0t", it.name, act, it.exp, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input int kind, input logic [31:0] v, input string nm);
      item_t it;
      it.kind = kind;
      it.exp  = v;
      it.name = nm;
      sb.push_back(it);
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
      tick();
      we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; ra0 = '0; ra1 = '0; we = 1'b0; wa = '0; wd = '0; clr_req = 1'b0;
      tick(); tick();
      reset_n = 1'b1;

      // 1: preload, confirm, then reset clears everything
      write_reg(5'd1, 32'hA1);
      write_reg(5'd2, 32'hA2);
      write_reg(5'd3, 32'hA3);
      ra0 = 5'd1; ra1 = 5'd3;
      expect_val(K_A_RD0, 32'hA1, "preload_a_r1");
      expect_val(K_B_RD1, 32'hA3, "preload_b_r3");
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ra0 = 5'(i); ra1 = 5'(i);
         expect_val(K_A_RD0, 32'h0, "reset_rd0");
         expect_val(K_B_RD1, 32'h0, "reset_b_rd1");
         expect_val(K_A_BUSY, 32'h0, "reset_busy");
         expect_val(K_A_DONE, 32'h0, "reset_done");
         tick();
      end

      // 2: write then read (bypass shows it early, no-bypass shows old 0)
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra0 = 5'd5;
      expect_val(K_A_RD0, 32'hDEADBEEF, "wr_bypass_a");
      expect_val(K_B_RD0, 32'h0, "wr_nobypass_b");
      tick();
      we = 1'b0;
      expect_val(K_A_RD0, 32'hDEADBEEF, "wr_read_a");
      expect_val(K_B_RD0, 32'hDEADBEEF, "wr_read_b");
      tick();

      // 3: zero register ignores writes and never bypasses
      we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra0 = 5'd0;
      expect_val(K_A_RD0, 32'h0, "zero_same_cycle");
      tick();
      we = 1'b0;
      expect_val(K_A_RD0, 32'h0, "zero_after");
      expect_val(K_B_RD0, 32'h0, "zero_after_b");
      tick();

      // 4: dual-port bypass
      write_reg(5'd7, 32'h11);
      we = 1'b1; wa = 5'd7; wd = 32'h22; ra0 = 5'd7; ra1 = 5'd7;
      expect_val(K_A_RD0, 32'h22, "byp_rd0");
      expect_val(K_A_RD1, 32'h22, "byp_rd1");
      expect_val(K_B_RD0, 32'h11, "nobyp_rd0");
      expect_val(K_B_RD1, 32'h11, "nobyp_rd1");
      tick();
      we = 1'b0;
      expect_val(K_A_RD0, 32'h22, "byp_after_a");
      expect_val(K_B_RD1, 32'h22, "nobyp_after_b");
      tick();

      // 5: bulk clear
      for (int i = 1; i < NREGS; i++) write_reg(5'(i), 32'(i));
      ra0 = 5'd31; ra1 = 5'd3;
      expect_val(K_A_RD0, 32'd31, "fill_r31");
      expect_val(K_A_RD1, 32'd3, "fill_r3");
      tick();
      clr_req = 1'b1;
      tick();
      for (int c = 0; c < 34; c++) begin
         if (c == 4) clr_req = 1'b0;
         we = 1'b0;
         if (c == 2) begin
            // regs 0,1 already cleared, reg 2 not yet
            ra0 = 5'd2; ra1 = 5'd1;
            expect_val(K_A_RD0, 32'd2, "clr_partial_r2");
            expect_val(K_A_RD1, 32'd0, "clr_partial_r1");
         end
         if (c == 10) begin
            we = 1'b1; wa = 5'd3; wd = 32'hAA; ra0 = 5'd3;
            expect_val(K_A_RD0, 32'h0, "clr_no_bypass");
         end
         expect_val(K_A_BUSY, (c < 32) ? 32'd1 : 32'd0, "clr_busy");
         expect_val(K_A_DONE, (c == 32) ? 32'd1 : 32'd0, "clr_done");
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         ra0 = 5'(i); ra1 = 5'(NREGS - 1 - i);
         expect_val(K_A_RD0, 32'h0, "clr_all_zero_a");
         expect_val(K_B_RD1, 32'h0, "clr_all_zero_b");
         tick();
      end

      // 6: reset in the middle of a clear
      for (int i = 1; i < NREGS; i++) write_reg(5'(i), 32'(i) + 32'h100);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra0 = 5'(i % NREGS); ra1 = 5'(NREGS - 1 - (i % NREGS));
         expect_val(K_A_BUSY, 32'h0, "midrst_busy");
         expect_val(K_A_DONE, 32'h0, "midrst_done");
         expect_val(K_A_RD0, 32'h0, "midrst_rd0");
         expect_val(K_A_RD1, 32'h0, "midrst_rd1");
         tick();
      end

      tick();
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule : tb_reg_file_bypass
`default_nettype wire
